// File: rtl/ball_motion_ctrl_if.sv
// Avalon-MM write-only master bundle between the ball motion controller and
// the ball display peripheral's byte-wide coordinate registers.
interface ball_motion_ctrl_if;
    logic       m_chipselect;
    logic       m_write;
    logic [2:0] m_address;
    logic [7:0] m_writedata;
    logic       m_waitrequest;

    modport master (
        output m_chipselect,
        output m_write,
        output m_address,
        output m_writedata,
        input  m_waitrequest
    );

    modport slave (
        input  m_chipselect,
        input  m_write,
        input  m_address,
        input  m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion controller.
// Once per frame it moves the ball centre by spd_x/spd_y, bounces it off the
// visible-area limits, then writes the new centre to the peripheral as four
// Avalon-MM byte writes (X high, X low, Y high, Y low).
// Optional feature macro: BALL_CTRL_DIFF_WRITE_EN -- when defined, writes for
// an axis whose coordinate did not change are skipped.
module ball_motion_ctrl #(
    parameter int H_MAX  = 639,
    parameter int V_MAX  = 479,
    parameter int RADIUS = 15,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                frame_tick,
    input  logic [3:0]          spd_x,
    input  logic [3:0]          spd_y,
    ball_motion_ctrl_if.master  m_bus,
    output logic [9:0]          x_pos,
    output logic [9:0]          y_pos,
    output logic                busy,
    output logic                overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_WR_XH = 3'd2;
    localparam logic [2:0] S_WR_XL = 3'd3;
    localparam logic [2:0] S_WR_YH = 3'd4;
    localparam logic [2:0] S_WR_YL = 3'd5;

    // Centre limits on each axis; 11-bit signed so pos-spd below zero compares correctly.
    localparam logic signed [10:0] X_HI = 11'(H_MAX - RADIUS);
    localparam logic signed [10:0] X_LO = 11'(RADIUS);
    localparam logic signed [10:0] Y_HI = 11'(V_MAX - RADIUS);
    localparam logic signed [10:0] Y_LO = 11'(RADIUS);

    logic [2:0]         r_state;
    logic [9:0]         r_xPos;
    logic [9:0]         r_yPos;
    logic               r_dirX;
    logic               r_dirY;
    logic               r_overrun;

    logic signed [10:0] w_sumX;
    logic signed [10:0] w_sumY;
    logic [9:0]         w_nxtX;
    logic [9:0]         w_nxtY;
    logic               w_nxtDirX;
    logic               w_nxtDirY;

`ifdef BALL_CTRL_DIFF_WRITE_EN
    logic               r_chgY;
    logic               w_chgX;
    logic               w_chgY;

    assign w_chgX = (w_nxtX != r_xPos);
    assign w_chgY = (w_nxtY != r_yPos);
`endif

    // Next X centre and direction: step by speed, clamp and reverse at either limit.
    always_comb begin
        w_sumX    = r_dirX ? ($signed({1'b0, r_xPos}) + $signed({7'b0, spd_x}))
                           : ($signed({1'b0, r_xPos}) - $signed({7'b0, spd_x}));
        w_nxtX    = r_xPos;
        w_nxtDirX = r_dirX;
        if (spd_x != 4'd0) begin
            if (w_sumX >= X_HI) begin
                w_nxtX    = X_HI[9:0];
                w_nxtDirX = 1'b0;
            end else if (w_sumX <= X_LO) begin
                w_nxtX    = X_LO[9:0];
                w_nxtDirX = 1'b1;
            end else begin
                w_nxtX    = w_sumX[9:0];
            end
        end
    end

    // Next Y centre and direction, same bounce rule as X.
    always_comb begin
        w_sumY    = r_dirY ? ($signed({1'b0, r_yPos}) + $signed({7'b0, spd_y}))
                           : ($signed({1'b0, r_yPos}) - $signed({7'b0, spd_y}));
        w_nxtY    = r_yPos;
        w_nxtDirY = r_dirY;
        if (spd_y != 4'd0) begin
            if (w_sumY >= Y_HI) begin
                w_nxtY    = Y_HI[9:0];
                w_nxtDirY = 1'b0;
            end else if (w_sumY <= Y_LO) begin
                w_nxtY    = Y_LO[9:0];
                w_nxtDirY = 1'b1;
            end else begin
                w_nxtY    = w_sumY[9:0];
            end
        end
    end

    // Sequencer: wait for a tick, update the centre in CALC, then walk the write states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_xPos  <= 10'(X_INIT);
            r_yPos  <= 10'(Y_INIT);
            r_dirX  <= 1'b1;
            r_dirY  <= 1'b1;
`ifdef BALL_CTRL_DIFF_WRITE_EN
            r_chgY  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick && enable) begin
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_xPos <= w_nxtX;
                    r_yPos <= w_nxtY;
                    r_dirX <= w_nxtDirX;
                    r_dirY <= w_nxtDirY;
`ifdef BALL_CTRL_DIFF_WRITE_EN
                    r_chgY <= w_chgY;
                    if (w_chgX) begin
                        r_state <= S_WR_XH;
                    end else if (w_chgY) begin
                        r_state <= S_WR_YH;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_WR_XH;
`endif
                end
                S_WR_XH: begin
                    if (!m_bus.m_waitrequest) begin
                        r_state <= S_WR_XL;
                    end
                end
                S_WR_XL: begin
                    if (!m_bus.m_waitrequest) begin
`ifdef BALL_CTRL_DIFF_WRITE_EN
                        r_state <= r_chgY ? S_WR_YH : S_IDLE;
`else
                        r_state <= S_WR_YH;
`endif
                    end
                end
                S_WR_YH: begin
                    if (!m_bus.m_waitrequest) begin
                        r_state <= S_WR_YL;
                    end
                end
                S_WR_YL: begin
                    if (!m_bus.m_waitrequest) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a tick seen while busy is dropped and flagged until enable drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (!enable) begin
            r_overrun <= 1'b0;
        end else if (frame_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    // Bus outputs decoded from state and the registered centre, so they hold during stalls.
    always_comb begin
        m_bus.m_write     = 1'b0;
        m_bus.m_address   = 3'd0;
        m_bus.m_writedata = 8'd0;
        case (r_state)
            S_WR_XH: begin
                m_bus.m_write     = 1'b1;
                m_bus.m_address   = 3'd0;
                m_bus.m_writedata = {6'b0, r_xPos[9:8]};
            end
            S_WR_XL: begin
                m_bus.m_write     = 1'b1;
                m_bus.m_address   = 3'd1;
                m_bus.m_writedata = r_xPos[7:0];
            end
            S_WR_YH: begin
                m_bus.m_write     = 1'b1;
                m_bus.m_address   = 3'd2;
                m_bus.m_writedata = {6'b0, r_yPos[9:8]};
            end
            S_WR_YL: begin
                m_bus.m_write     = 1'b1;
                m_bus.m_address   = 3'd3;
                m_bus.m_writedata = r_yPos[7:0];
            end
            default: begin
                m_bus.m_write     = 1'b0;
            end
        endcase
        m_bus.m_chipselect = m_bus.m_write;
    end

    assign x_pos   = r_xPos;
    assign y_pos   = r_yPos;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule
